key_event_57: RTL
=================

# key_event_57

Key event decoder for the digital clock's user buttons. It consumes the clean, active-high level from a key debouncer and turns it into single-cycle action pulses: press, release, short click, long hold and auto-repeat. The clock's time-setting logic uses these pulses directly. One instance sits after each debounced key, in the `clk_50m_57` domain.

## Interface
Parameters:
- `LONG_CYCLES`, default 50_000_000: consecutive high samples needed to declare a long press (1 s at 50 MHz). Legal range ≥ 2.
- `REPEAT_CYCLES`, default 10_000_000: consecutive high samples between auto-repeat pulses after a long press (200 ms). A value of 0 disables repeat.
- `CNT_W`, default derived: counter width, equal to clog2(max(LONG_CYCLES, REPEAT_CYCLES) + 1).

Ports:
- `clk_50m_57`  in  1  system clock, 50 MHz.
- `rst_57`  in  1  reset, asynchronous, active-high.
- `key_level_57`  in  1  debounced key level, 1 = pressed. Already synchronous to `clk_50m_57`.
- `press_pulse_57`  out  1  one-cycle pulse on press.
- `release_pulse_57`  out  1  one-cycle pulse on every release.
- `short_pulse_57`  out  1  one-cycle pulse on a release that comes before the long threshold.
- `long_pulse_57`  out  1  one-cycle pulse when the long threshold is reached.
- `repeat_pulse_57`  out  1  one-cycle pulse every `REPEAT_CYCLES` samples while held after a long press.
- `held_57`  out  1  level, 1 while a press is being tracked (PRESSED or LONG).

## Operation
- All outputs are registered. Reset value of every output is 0, the state is ARM and the counter is 0.
- State ARM: ignores presses until the key is released.
  - On an edge where `key_level_57` = 0, go to IDLE. No outputs.
  - A key held through reset never produces a press.
- State IDLE:
  - On an edge where `key_level_57` = 1, go to PRESSED, set cnt = 1, pulse `press_pulse_57`, set `held_57` = 1.
- State PRESSED:
  - Key sampled 1:
    - If cnt == LONG_CYCLES-1: go to LONG, set cnt = 0, pulse `long_pulse_57`.
    - Otherwise cnt increments.
  - Key sampled 0: go to IDLE, pulse `release_pulse_57` and `short_pulse_57` together, set `held_57` = 0.
- State LONG:
  - Key sampled 1 with REPEAT_CYCLES ≠ 0: cnt increments.
    - When cnt == REPEAT_CYCLES-1, pulse `repeat_pulse_57` and set cnt = 0.
  - Key sampled 1 with REPEAT_CYCLES = 0: cnt holds at 0 and no repeat pulses occur.
  - Key sampled 0: go to IDLE, pulse `release_pulse_57` only, set `held_57` = 0.
- Pulse exclusivity: `long_pulse_57` and `repeat_pulse_57` are never high in the same cycle. `short_pulse_57` is never high without `release_pulse_57`.
- Counter arithmetic is unsigned in `CNT_W` bits. The compare thresholds keep the counter from wrapping.
- The block has no press-count memory: every IDLE→PRESSED transition is an independent event.

## Timing
- Latency: each pulse is high for exactly the one cycle after the clock edge that samples the triggering level.
- Counting edges from the first high sample as edge 1:
  - Long: `long_pulse_57` follows edge LONG_CYCLES.
  - Repeat: pulse n follows edge LONG_CYCLES + n·REPEAT_CYCLES.
- Boundary at the long threshold:
  - LONG_CYCLES-1 high samples followed by a low sample give a short click.
  - Exactly LONG_CYCLES high samples give a long press.
  - If the key is low on the threshold edge, that edge is a release and no long press occurs.
- Minimum press: a single high sample between lows produces a press pulse followed by release and short pulses in the next cycle.
  - Back-to-back presses are accepted after one low sample.
- Reset mid-operation: `rst_57` clears outputs immediately, without waiting for a clock edge. Any pending pulse is lost and the state returns to ARM.

## Test plan
Use LONG_CYCLES = 8 and REPEAT_CYCLES = 3 unless stated otherwise.
- After reset, key low for 2 cycles, then high for 5 cycles, then low:
  - `press_pulse_57` follows high edge 1.
  - `release_pulse_57` and `short_pulse_57` follow the first low edge.
  - No long or repeat pulse.
- Key high for exactly 7 cycles, then low: short click. Key high for exactly 8 cycles, then low: `long_pulse_57` after edge 8, and on release only `release_pulse_57` (no short).
- Key high for 17 cycles: `long_pulse_57` after edge 8, `repeat_pulse_57` after edges 11, 14 and 17, and `held_57` = 1 throughout.
- Assert `rst_57` while in LONG with the key high, then deassert while the key stays high for 10 cycles:
  - All outputs are 0 immediately and stay 0 while the key stays high.
  - After 1 low cycle and a new high sample, `press_pulse_57` fires.
- With REPEAT_CYCLES = 0, key high for 20 cycles: exactly one `long_pulse_57` and zero `repeat_pulse_57`.
- Key alternating 1, 0, 1, 0: two press/release/short triplets with correct one-cycle spacing.

Source files
------------

// File: rtl/key_event_57.sv
// key_event_57
//   Turns a debounced, active-high key level into single-cycle action pulses
//   for the clock's time-setting logic: press, release, short click, long
//   hold and auto-repeat. Every output is registered.
//
// Ports
//   clk_50m_57        in   system clock (50 MHz)
//   rst_57            in   asynchronous active-high reset
//   key_level_57      in   debounced key level, 1 = pressed (already in clk domain)
//   press_pulse_57    out  one cycle after the first high sample of a press
//   release_pulse_57  out  one cycle after every release
//   short_pulse_57    out  with release_pulse_57 when released before the long threshold
//   long_pulse_57     out  one cycle when LONG_CYCLES consecutive high samples are seen
//   repeat_pulse_57   out  every REPEAT_CYCLES high samples after the long pulse
//   held_57           out  level, high while a press is being tracked

module key_event_57 #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int CNT_W = $clog2(((LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES) + 1)
) (
  input  logic clk_50m_57,
  input  logic rst_57,
  input  logic key_level_57,
  output logic press_pulse_57,
  output logic release_pulse_57,
  output logic short_pulse_57,
  output logic long_pulse_57,
  output logic repeat_pulse_57,
  output logic held_57
);

  // ARM waits for the key to be released so a key held through reset
  // never produces a press.
  localparam logic [1:0] ST_ARM     = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_PRESSED = 2'd2;
  localparam logic [1:0] ST_LONG    = 2'd3;

  localparam bit             REPEAT_EN   = (REPEAT_CYCLES != 0);
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = REPEAT_EN ? CNT_W'(REPEAT_CYCLES - 1) : '0;

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic press_reg, press_next;
  logic release_reg, release_next;
  logic short_reg, short_next;
  logic long_reg, long_next;
  logic repeat_reg, repeat_next;
  logic held_reg, held_next;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    short_next   = 1'b0;
    long_next    = 1'b0;
    repeat_next  = 1'b0;

    case (state_reg)
      ST_ARM: begin
        if (!key_level_57) begin
          state_next = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (key_level_57) begin
          state_next = ST_PRESSED;
          // The sample that enters PRESSED is already high sample #1.
          cnt_next   = CNT_W'(1);
          press_next = 1'b1;
        end
      end

      ST_PRESSED: begin
        if (key_level_57) begin
          if (cnt_reg == LONG_LAST) begin
            state_next = ST_LONG;
            cnt_next   = '0;
            long_next  = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end else begin
          state_next   = ST_IDLE;
          cnt_next     = '0;
          release_next = 1'b1;
          short_next   = 1'b1;
        end
      end

      ST_LONG: begin
        if (key_level_57) begin
          if (REPEAT_EN) begin
            // Counter restarts on each repeat, so it never exceeds REPEAT_LAST.
            if (cnt_reg == REPEAT_LAST) begin
              cnt_next    = '0;
              repeat_next = 1'b1;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end else begin
            cnt_next = '0;
          end
        end else begin
          state_next   = ST_IDLE;
          cnt_next     = '0;
          release_next = 1'b1;
        end
      end

      default: begin
        state_next = ST_ARM;
        cnt_next   = '0;
      end
    endcase

    held_next = (state_next == ST_PRESSED) || (state_next == ST_LONG);
  end

  always_ff @(posedge clk_50m_57 or posedge rst_57) begin
    if (rst_57) begin
      state_reg   <= ST_ARM;
      cnt_reg     <= '0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      short_reg   <= 1'b0;
      long_reg    <= 1'b0;
      repeat_reg  <= 1'b0;
      held_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      press_reg   <= press_next;
      release_reg <= release_next;
      short_reg   <= short_next;
      long_reg    <= long_next;
      repeat_reg  <= repeat_next;
      held_reg    <= held_next;
    end
  end

  assign press_pulse_57   = press_reg;
  assign release_pulse_57 = release_reg;
  assign short_pulse_57   = short_reg;
  assign long_pulse_57    = long_reg;
  assign repeat_pulse_57  = repeat_reg;
  assign held_57          = held_reg;

endmodule
